alu_control_unit: RTL and testbench
===================================

Name: alu_control_unit

Overview:
- Instruction sequencer that drives the 8-bit ALU and the register file around it.
- Accepts one 32-bit instruction per valid/ready handshake and decodes it into ALU select, operand-source and negate controls, and register addresses.
- Waits out the ALU latency class for the operation, then issues a single-cycle register write-enable.
- Sits between instruction fetch and the ALU/register-file datapath.

Parameters:
- SHORT_WAIT, 1, EXECUTE cycles for forward/and/or.
- LONG_WAIT, 2, EXECUTE cycles for add/sub.
- REG_AW, 3, register address width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- INSTRUCTION  input  32  fields: [31:24] opcode, [23:16] dest (low REG_AW bits used), [15:8] src1, [7:0] src2 or immediate.
- INSTR_VALID  input  1  instruction present.
- INSTR_READY  output  1  unit can accept an instruction.
- ALUOP  output  3  ALU select: 000 forward, 001 add, 010 and, 011 or.
- IMMEDIATE  output  8  INSTRUCTION[7:0] registered at accept.
- IMM_SEL  output  1  1 = ALU data2 comes from IMMEDIATE.
- NEG_SEL  output  1  1 = data2 is two's-complemented before the ALU (sub).
- OUT1ADDRESS  output  REG_AW  register read address 1.
- OUT2ADDRESS  output  REG_AW  register read address 2.
- INADDRESS  output  REG_AW  register write address.
- WRITEENABLE  output  1  register write strobe.
- ILLEGAL  output  1  single-cycle pulse on an undefined opcode.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - RESET is sampled on CLK; it is synchronous and active-high.
  - Reset sends the FSM to IDLE and forces all outputs to 0, except INSTR_READY, which is 1.
  - Reset asserted mid-instruction aborts it. No WRITEENABLE follows.
- States:
  - IDLE:
    - INSTR_READY=1.
    - INSTR_VALID && INSTR_READY at an edge is an accept. The instruction is latched and the next state is DECODE.
  - DECODE:
    - One cycle. Registers ALUOP, IMM_SEL, NEG_SEL, the addresses and IMMEDIATE. Loads the wait counter.
    - On an illegal opcode: ILLEGAL=1 for this cycle, next state IDLE, no write.
  - EXECUTE:
    - Controls are held stable.
    - The counter decrements each cycle. When it reaches 1, the next state is WRITEBACK.
    - Duration is SHORT_WAIT or LONG_WAIT cycles.
  - WRITEBACK:
    - WRITEENABLE=1 for exactly this one cycle; controls still held.
    - Next state is IDLE.
- Opcode decode:
  - 0x00 loadi: ALUOP=000, IMM_SEL=1, short wait.
  - 0x01 mov: ALUOP=000, IMM_SEL=0, short wait.
  - 0x02 add: ALUOP=001, short wait replaced by LONG_WAIT.
  - 0x03 sub: ALUOP=001, NEG_SEL=1, LONG_WAIT.
  - 0x04 and: ALUOP=010, short wait.
  - 0x05 or: ALUOP=011, short wait.
  - Any other opcode: illegal.
- Address mapping:
  - INADDRESS=[18:16].
  - OUT1ADDRESS=[10:8].
  - OUT2ADDRESS=[2:0].
  - Upper field bits are ignored, with no error.
- Latency: accept to WRITEENABLE is 1+SHORT_WAIT+1 cycles (3 by default) or 1+LONG_WAIT+1 cycles (4 by default).
- Throughput:
  - INSTR_READY is 0 from the cycle after accept until the FSM re-enters IDLE.
  - The earliest next accept is the cycle after WRITEBACK (or after DECODE for an illegal opcode).
- Handshake rules:
  - INSTR_VALID while not ready is ignored. The instruction is not captured.
  - The INSTRUCTION value matters only at the accept edge.
- Hold rules:
  - ALUOP, IMM_SEL, NEG_SEL and the addresses hold their last values in IDLE.
  - WRITEENABLE is never 1 outside WRITEBACK.
- Simultaneous RESET and INSTR_VALID: reset wins. The instruction is not accepted.

Optional Feature:
- Macro: ALU_CTRL_STATS_EN.
- Defined:
  - Adds output RETIRED_COUNT (16 bits). It increments once per WRITEBACK cycle, wraps 0xFFFF to 0x0000, and clears on RESET.
  - Adds output ILLEGAL_COUNT (8 bits). It increments on each ILLEGAL pulse and saturates at 0xFF.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

Test Plan:
- Reset then loadi 0x00_03_00_2A:
  - DECODE: ALUOP=000, IMM_SEL=1, IMMEDIATE=0x2A.
  - WRITEENABLE=1 with INADDRESS=3 exactly 3 cycles after accept.
  - INSTR_READY=1 the next cycle.
- sub 0x03_01_02_05:
  - ALUOP=001, NEG_SEL=1, OUT1ADDRESS=2, OUT2ADDRESS=5.
  - WRITEENABLE pulse 4 cycles after accept, INADDRESS=1.
- Opcode 0x07:
  - ILLEGAL pulses once in DECODE.
  - No WRITEENABLE.
  - INSTR_READY=1 two cycles after accept.
- Back-to-back and 0x04_02_01_00 then or 0x05_04_03_01, with INSTR_VALID held high:
  - The second instruction is accepted the cycle after the first WRITEBACK.
  - Exactly two WRITEENABLE pulses, INADDRESS 2 then 4.
- Add accepted, RESET asserted in the first EXECUTE cycle:
  - Next edge: state IDLE, all outputs 0, INSTR_READY=1.
  - No WRITEENABLE ever for that instruction.
- With ALU_CTRL_STATS_EN: 3 legal instructions and 1 illegal instruction give RETIRED_COUNT=3 and ILLEGAL_COUNT=1. RESET clears both to 0.

Source files
------------

// File: rtl/alu_control_unit_if.sv
// Instruction/control bus between fetch, alu_control_unit and the ALU/register-file datapath.
// ALU_CTRL_STATS_EN adds the retired/illegal counter signals.
interface alu_control_unit_if #(
   parameter int unsigned REG_AW = 3
);
   logic [31:0]       INSTRUCTION;
   logic              INSTR_VALID;
   logic              INSTR_READY;
   logic [2:0]        ALUOP;
   logic [7:0]        IMMEDIATE;
   logic              IMM_SEL;
   logic              NEG_SEL;
   logic [REG_AW-1:0] OUT1ADDRESS;
   logic [REG_AW-1:0] OUT2ADDRESS;
   logic [REG_AW-1:0] INADDRESS;
   logic              WRITEENABLE;
   logic              ILLEGAL;
   logic              BUSY;
`ifdef ALU_CTRL_STATS_EN
   logic [15:0]       RETIRED_COUNT;
   logic [7:0]        ILLEGAL_COUNT;
`endif

   modport master (
      output INSTRUCTION, INSTR_VALID,
      input  INSTR_READY, ALUOP, IMMEDIATE, IMM_SEL, NEG_SEL,
             OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITEENABLE, ILLEGAL, BUSY
`ifdef ALU_CTRL_STATS_EN
      , input RETIRED_COUNT, ILLEGAL_COUNT
`endif
   );

   modport slave (
      input  INSTRUCTION, INSTR_VALID,
      output INSTR_READY, ALUOP, IMMEDIATE, IMM_SEL, NEG_SEL,
             OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITEENABLE, ILLEGAL, BUSY
`ifdef ALU_CTRL_STATS_EN
      , output RETIRED_COUNT, ILLEGAL_COUNT
`endif
   );
endinterface

// File: rtl/alu_control_unit.sv
// Instruction sequencer for the 8-bit ALU: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Optional ALU_CTRL_STATS_EN adds RETIRED_COUNT / ILLEGAL_COUNT on the bus.
module alu_control_unit #(
   parameter int unsigned SHORT_WAIT = 1,
   parameter int unsigned LONG_WAIT  = 2,
   parameter int unsigned REG_AW     = 3
) (
   input logic             CLK,
   input logic             RESET,
   alu_control_unit_if.slave bus
);

   localparam int unsigned MAXW = (LONG_WAIT > SHORT_WAIT) ? LONG_WAIT : SHORT_WAIT;
   localparam int unsigned CW   = $clog2(MAXW + 1);

   typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic [7:0]    opcode;
   logic          legal;
   logic [2:0]    dec_aluop;
   logic          dec_imm;
   logic          dec_neg;
   logic [CW-1:0] dec_wait;
   logic          unused_fields;

   assign opcode        = bus.INSTRUCTION[31:24];
   assign unused_fields = ^{bus.INSTRUCTION[23:16+REG_AW], bus.INSTRUCTION[15:8+REG_AW]};

   always_comb begin
      legal     = 1'b1;
      dec_aluop = 3'b000;
      dec_imm   = 1'b0;
      dec_neg   = 1'b0;
      dec_wait  = CW'(SHORT_WAIT);
      case (opcode)
         8'h00: dec_imm = 1'b1;
         8'h01: dec_imm = 1'b0;
         8'h02: begin
            dec_aluop = 3'b001;
            dec_wait  = CW'(LONG_WAIT);
         end
         8'h03: begin
            dec_aluop = 3'b001;
            dec_neg   = 1'b1;
            dec_wait  = CW'(LONG_WAIT);
         end
         8'h04: dec_aluop = 3'b010;
         8'h05: dec_aluop = 3'b011;
         default: legal = 1'b0;
      endcase
   end

   // Decode happens at the accept edge so the controls and ILLEGAL are visible during DECODE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.INSTR_READY <= 1'b1;
         bus.ALUOP       <= '0;
         bus.IMMEDIATE   <= '0;
         bus.IMM_SEL     <= 1'b0;
         bus.NEG_SEL     <= 1'b0;
         bus.OUT1ADDRESS <= '0;
         bus.OUT2ADDRESS <= '0;
         bus.INADDRESS   <= '0;
         bus.WRITEENABLE <= 1'b0;
         bus.ILLEGAL     <= 1'b0;
         bus.BUSY        <= 1'b0;
`ifdef ALU_CTRL_STATS_EN
         bus.RETIRED_COUNT <= '0;
         bus.ILLEGAL_COUNT <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.INSTR_VALID && bus.INSTR_READY) begin
                  state           <= DECODE;
                  bus.INSTR_READY <= 1'b0;
                  bus.BUSY        <= 1'b1;
                  bus.IMMEDIATE   <= bus.INSTRUCTION[7:0];
                  bus.INADDRESS   <= bus.INSTRUCTION[16 +: REG_AW];
                  bus.OUT1ADDRESS <= bus.INSTRUCTION[8 +: REG_AW];
                  bus.OUT2ADDRESS <= bus.INSTRUCTION[0 +: REG_AW];
                  bus.ILLEGAL     <= ~legal;
                  cnt             <= dec_wait;
                  if (legal) begin
                     bus.ALUOP   <= dec_aluop;
                     bus.IMM_SEL <= dec_imm;
                     bus.NEG_SEL <= dec_neg;
                  end
               end
            end
            DECODE: begin
               if (bus.ILLEGAL) begin
                  state           <= IDLE;
                  bus.ILLEGAL     <= 1'b0;
                  bus.INSTR_READY <= 1'b1;
                  bus.BUSY        <= 1'b0;
`ifdef ALU_CTRL_STATS_EN
                  if (bus.ILLEGAL_COUNT != 8'hFF)
                     bus.ILLEGAL_COUNT <= bus.ILLEGAL_COUNT + 8'd1;
`endif
               end else begin
                  state <= EXECUTE;
               end
            end
            EXECUTE: begin
               if (cnt <= CW'(1)) begin
                  state           <= WRITEBACK;
                  bus.WRITEENABLE <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            WRITEBACK: begin
               state           <= IDLE;
               bus.WRITEENABLE <= 1'b0;
               bus.INSTR_READY <= 1'b1;
               bus.BUSY        <= 1'b0;
`ifdef ALU_CTRL_STATS_EN
               bus.RETIRED_COUNT <= bus.RETIRED_COUNT + 16'd1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed plan steps plus random instructions
// checked against a cycle-timeline reference model.
module tb_alu_control_unit;

   localparam int unsigned SW = 1;
   localparam int unsigned LW = 2;
   localparam int unsigned AW = 3;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   we_count = 0;

   logic [2:0]    exp_aluop;
   logic          exp_imm, exp_neg;
   logic [7:0]    exp_immv;
   logic [AW-1:0] exp_a1, exp_a2, exp_ad;
   int            exp_retired, exp_illegal;

   alu_control_unit_if #(.REG_AW(AW)) bus ();

   alu_control_unit #(.SHORT_WAIT(SW), .LONG_WAIT(LW), .REG_AW(AW)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.WRITEENABLE === 1'b1) we_count++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode table: opcode -> controls and EXECUTE length.
   function automatic void ref_decode(input logic [7:0] op, output bit lg, output logic [2:0] aop,
                                      output bit im, output bit ng, output int unsigned w);
      lg = 1; aop = 3'd0; im = 0; ng = 0; w = SW;
      case (op)
         8'h00: im = 1;
         8'h01: im = 0;
         8'h02: begin aop = 3'd1; w = LW; end
         8'h03: begin aop = 3'd1; ng = 1; w = LW; end
         8'h04: aop = 3'd2;
         8'h05: aop = 3'd3;
         default: lg = 0;
      endcase
   endfunction

   task automatic check_ctrl(input string ph);
      check({ph, "_aluop"}, 32'(bus.ALUOP), 32'(exp_aluop));
      check({ph, "_imm_sel"}, 32'(bus.IMM_SEL), 32'(exp_imm));
      check({ph, "_neg_sel"}, 32'(bus.NEG_SEL), 32'(exp_neg));
      check({ph, "_immediate"}, 32'(bus.IMMEDIATE), 32'(exp_immv));
      check({ph, "_out1"}, 32'(bus.OUT1ADDRESS), 32'(exp_a1));
      check({ph, "_out2"}, 32'(bus.OUT2ADDRESS), 32'(exp_a2));
      check({ph, "_inaddr"}, 32'(bus.INADDRESS), 32'(exp_ad));
   endtask

   task automatic reset_expect();
      exp_aluop = '0; exp_imm = 0; exp_neg = 0; exp_immv = '0;
      exp_a1 = '0; exp_a2 = '0; exp_ad = '0;
      exp_retired = 0; exp_illegal = 0;
   endtask

   // Presents ins, follows it through its whole timeline; keep holds VALID with nxt afterwards.
   task automatic do_instr(input logic [31:0] ins, input bit keep, input logic [31:0] nxt);
      bit lg, im, ng;
      logic [2:0] aop;
      int unsigned w;
      for (int k = 0; k < 20 && bus.INSTR_READY !== 1'b1; k++) tick();
      check("ready_before_accept", 32'(bus.INSTR_READY), 32'd1);
      if (bus.INSTR_READY !== 1'b1) return;
      ref_decode(ins[31:24], lg, aop, im, ng, w);
      bus.INSTRUCTION = ins;
      bus.INSTR_VALID = 1'b1;
      tick();
      exp_immv = ins[7:0];
      exp_ad   = ins[16 +: AW];
      exp_a1   = ins[8 +: AW];
      exp_a2   = ins[0 +: AW];
      if (lg) begin exp_aluop = aop; exp_imm = im; exp_neg = ng; end
      if (keep) begin
         bus.INSTR_VALID = 1'b1;
         bus.INSTRUCTION = nxt;
      end else begin
         bus.INSTR_VALID = 1'($urandom);
         bus.INSTRUCTION = $urandom;
      end
      check("dec_illegal", 32'(bus.ILLEGAL), 32'(!lg));
      check("dec_we", 32'(bus.WRITEENABLE), 32'd0);
      check("dec_ready", 32'(bus.INSTR_READY), 32'd0);
      check("dec_busy", 32'(bus.BUSY), 32'd1);
      check_ctrl("dec");
      if (lg) begin
         for (int unsigned i = 0; i < w; i++) begin
            tick();
            check("exe_we", 32'(bus.WRITEENABLE), 32'd0);
            check("exe_ready", 32'(bus.INSTR_READY), 32'd0);
            check("exe_aluop", 32'(bus.ALUOP), 32'(exp_aluop));
         end
         tick();
         check("wb_we", 32'(bus.WRITEENABLE), 32'd1);
         check("wb_ready", 32'(bus.INSTR_READY), 32'd0);
         check_ctrl("wb");
         exp_retired++;
      end else begin
         if (exp_illegal < 255) exp_illegal++;
      end
      tick();
      check("idle_ready", 32'(bus.INSTR_READY), 32'd1);
      check("idle_we", 32'(bus.WRITEENABLE), 32'd0);
      check("idle_busy", 32'(bus.BUSY), 32'd0);
      check("idle_illegal", 32'(bus.ILLEGAL), 32'd0);
      check_ctrl("idle");
      if (!keep) bus.INSTR_VALID = 1'b0;
   endtask

   initial begin
      logic [31:0] q[$];
      int wc;
      rst = 1'b1;
      bus.INSTR_VALID = 1'b0;
      bus.INSTRUCTION = '0;
      reset_expect();
      tick();
      tick();
      check("rst_ready", 32'(bus.INSTR_READY), 32'd1);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_we", 32'(bus.WRITEENABLE), 32'd0);
      check("rst_illegal", 32'(bus.ILLEGAL), 32'd0);
      check_ctrl("rst");
      rst = 1'b0;
      tick();

      do_instr(32'h0003002A, 0, 32'h0);
      do_instr(32'h03010205, 0, 32'h0);
      wc = we_count;
      do_instr(32'h07000000, 0, 32'h0);
      check("illegal_no_we", 32'(we_count), 32'(wc));

      wc = we_count;
      do_instr(32'h04020100, 1, 32'h05040301);
      do_instr(32'h05040301, 0, 32'h0);
      check("b2b_we_pulses", 32'(we_count - wc), 32'd2);

      // Abort an add during its first EXECUTE cycle.
      bus.INSTRUCTION = 32'h02050607;
      bus.INSTR_VALID = 1'b1;
      tick();
      bus.INSTR_VALID = 1'b0;
      tick();
      wc = we_count;
      rst = 1'b1;
      tick();
      reset_expect();
      check("abort_ready", 32'(bus.INSTR_READY), 32'd1);
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_we", 32'(bus.WRITEENABLE), 32'd0);
      check_ctrl("abort");
      rst = 1'b0;
      repeat (5) tick();
      check("abort_no_we", 32'(we_count), 32'(wc));

      // Reset and VALID together: reset wins.
      rst = 1'b1;
      bus.INSTRUCTION = 32'h01070605;
      bus.INSTR_VALID = 1'b1;
      tick();
      rst = 1'b0;
      bus.INSTR_VALID = 1'b0;
      check("rstvalid_ready", 32'(bus.INSTR_READY), 32'd1);
      tick();
      check("rstvalid_busy", 32'(bus.BUSY), 32'd0);
      check_ctrl("rstvalid");

      for (int i = 0; i < 40; i++) begin
         logic [7:0] op;
         op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         q.push_back({op, 24'($urandom)});
      end
      for (int i = 0; i < q.size(); i++) begin
         bit kp;
         kp = (i + 1 < q.size()) && ($urandom_range(0, 1) == 1);
         do_instr(q[i], kp, kp ? q[i+1] : 32'h0);
      end

`ifdef ALU_CTRL_STATS_EN
      check("retired_count", 32'(bus.RETIRED_COUNT), 32'(exp_retired));
      check("illegal_count", 32'(bus.ILLEGAL_COUNT), 32'(exp_illegal));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("retired_clr", 32'(bus.RETIRED_COUNT), 32'd0);
      check("illegal_clr", 32'(bus.ILLEGAL_COUNT), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
